// File: rtl/video_timing_gen.sv
// Parametrised raster timing generator for the pixel clock domain: h/v counters,
// registered sync/blank/position decode, line/frame strobes, frame counter and resync.
module video_timing_gen #(
  parameter int unsigned CW       = 12,
  parameter int unsigned FC_W     = 16,
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter logic        HS_POL   = 1'b0,
  parameter logic        VS_POL   = 1'b0
) (
  input  logic            clk_pixel,
  input  logic            rst_pixel_n,
  input  logic            ce,
  input  logic            resync,
  output logic            hsync,
  output logic            vsync,
  output logic            de,
  output logic            blank,
  output logic            vblank,
  output logic [CW-1:0]   pixel_x,
  output logic [CW-1:0]   pixel_y,
  output logic            line_start,
  output logic            frame_start,
  output logic [FC_W-1:0] frame_count
);

  localparam int unsigned H_TOTAL      = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL      = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned H_SYNC_START = H_ACTIVE + H_FP;
  localparam int unsigned H_SYNC_END   = H_SYNC_START + H_SYNC;
  localparam int unsigned V_SYNC_START = V_ACTIVE + V_FP;
  localparam int unsigned V_SYNC_END   = V_SYNC_START + V_SYNC;

  // Reject geometries the counters cannot represent or that make no sense.
  if (64'(H_TOTAL) > (64'd1 << CW) || 64'(V_TOTAL) > (64'd1 << CW)) begin : g_bad_total
    $error("video_timing_gen: H_TOTAL or V_TOTAL exceeds 2**CW");
  end
  if (H_ACTIVE == 0 || V_ACTIVE == 0 || H_SYNC == 0 || V_SYNC == 0) begin : g_bad_zero
    $error("video_timing_gen: H_ACTIVE, V_ACTIVE, H_SYNC and V_SYNC must be non-zero");
  end

  logic [CW-1:0] hc;
  logic [CW-1:0] vc;
  logic [CW-1:0] hc_nxt;
  logic [CW-1:0] vc_nxt;
  logic          pending;
  int unsigned   hc_u;
  int unsigned   vc_u;
  logic          h_act;
  logic          v_act;
  logic          h_sync_on;
  logic          v_sync_on;
  logic          h_last;
  logic          v_last;
  logic          at_origin;

  // Position decode of the current counter values.
  always_comb begin
    hc_u      = 32'(hc);
    vc_u      = 32'(vc);
    h_act     = hc_u < H_ACTIVE;
    v_act     = vc_u < V_ACTIVE;
    h_sync_on = (hc_u >= H_SYNC_START) && (hc_u < H_SYNC_END);
    v_sync_on = (vc_u >= V_SYNC_START) && (vc_u < V_SYNC_END);
    h_last    = hc_u == H_TOTAL - 1;
    v_last    = vc_u == V_TOTAL - 1;
    at_origin = (hc == '0) && (vc == '0);
  end

  // Counter advance; a pending resync overrides the natural step with a restart.
  always_comb begin
    hc_nxt = hc + CW'(1);
    vc_nxt = vc;
    if (pending) begin
      hc_nxt = '0;
      vc_nxt = '0;
    end else if (h_last) begin
      hc_nxt = '0;
      vc_nxt = v_last ? '0 : vc + CW'(1);
    end
  end

  always_ff @(posedge clk_pixel or negedge rst_pixel_n) begin
    if (!rst_pixel_n) begin
      hc          <= '0;
      vc          <= '0;
      pending     <= 1'b0;
      hsync       <= ~HS_POL;
      vsync       <= ~VS_POL;
      de          <= 1'b0;
      blank       <= 1'b1;
      vblank      <= 1'b1;
      pixel_x     <= '0;
      pixel_y     <= '0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      frame_count <= '0;
    end else begin
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      if (ce) begin
        hsync       <= h_sync_on ? HS_POL : ~HS_POL;
        vsync       <= v_sync_on ? VS_POL : ~VS_POL;
        de          <= h_act && v_act;
        blank       <= !(h_act && v_act);
        vblank      <= !v_act;
        pixel_x     <= h_act ? hc : '0;
        pixel_y     <= v_act ? vc : '0;
        line_start  <= hc == '0;
        frame_start <= at_origin;
        if (at_origin) frame_count <= frame_count + FC_W'(1);
        hc          <= hc_nxt;
        vc          <= vc_nxt;
      end
      // A new request wins over the clear so a held resync keeps restarting.
      if (resync)  pending <= 1'b1;
      else if (ce) pending <= 1'b0;
    end
  end

endmodule

// File: tb/tb_video_timing_gen.sv
// Scoreboard bench for video_timing_gen on a small raster: a linear-position model
// predicts every registered output; a monitor compares after each clock edge.
module tb_video_timing_gen;

  localparam int unsigned CW       = 5;
  localparam int unsigned FC_W     = 4;
  localparam int unsigned HA       = 10;
  localparam int unsigned HFP      = 2;
  localparam int unsigned HS       = 3;
  localparam int unsigned HBP      = 2;
  localparam int unsigned VA       = 6;
  localparam int unsigned VFP      = 1;
  localparam int unsigned VS       = 2;
  localparam int unsigned VBP      = 2;
  localparam logic        HS_POL   = 1'b1;
  localparam logic        VS_POL   = 1'b0;
  localparam int          HT       = int'(HA + HFP + HS + HBP);
  localparam int          VT       = int'(VA + VFP + VS + VBP);
  localparam int          F        = HT * VT;

  typedef struct packed {
    logic            hs;
    logic            vs;
    logic            de;
    logic            blank;
    logic            vblank;
    logic [CW-1:0]   px;
    logic [CW-1:0]   py;
    logic            ls;
    logic            fs;
    logic [FC_W-1:0] fc;
  } out_t;

  logic            clk_pixel = 1'b0;
  logic            rst_pixel_n = 1'b1;
  logic            ce = 1'b0;
  logic            resync = 1'b0;
  logic            hsync, vsync, de, blank, vblank, line_start, frame_start;
  logic [CW-1:0]   pixel_x, pixel_y;
  logic [FC_W-1:0] frame_count;

  video_timing_gen #(
    .CW(CW), .FC_W(FC_W),
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
    .HS_POL(HS_POL), .VS_POL(VS_POL)
  ) dut (
    .clk_pixel(clk_pixel), .rst_pixel_n(rst_pixel_n), .ce(ce), .resync(resync),
    .hsync(hsync), .vsync(vsync), .de(de), .blank(blank), .vblank(vblank),
    .pixel_x(pixel_x), .pixel_y(pixel_y), .line_start(line_start),
    .frame_start(frame_start), .frame_count(frame_count)
  );

  initial forever #5 clk_pixel = ~clk_pixel;

  int   n_tests = 0;
  int   n_fail  = 0;
  out_t exp_q[$];

  // Reference model: raster position as a single index into the frame.
  int              m_p;
  bit              m_pend;
  logic [FC_W-1:0] m_fc;
  out_t            m_out;

  function automatic out_t reset_out();
    out_t r = '0;
    r.hs = ~HS_POL;
    r.vs = ~VS_POL;
    r.blank = 1'b1;
    r.vblank = 1'b1;
    return r;
  endfunction

  function automatic out_t dut_out();
    out_t r;
    r.hs = hsync; r.vs = vsync; r.de = de; r.blank = blank; r.vblank = vblank;
    r.px = pixel_x; r.py = pixel_y; r.ls = line_start; r.fs = frame_start;
    r.fc = frame_count;
    return r;
  endfunction

  task automatic model_reset();
    m_p = 0; m_pend = 0; m_fc = '0; m_out = reset_out();
  endtask

  task automatic model_step(input bit c, input bit r);
    int x, y;
    m_out.ls = 1'b0;
    m_out.fs = 1'b0;
    if (c) begin
      x = m_p % HT;
      y = m_p / HT;
      m_out.hs     = (x >= HA + HFP && x < HA + HFP + HS) ? HS_POL : ~HS_POL;
      m_out.vs     = (y >= VA + VFP && y < VA + VFP + VS) ? VS_POL : ~VS_POL;
      m_out.de     = (x < HA) && (y < VA);
      m_out.blank  = !m_out.de;
      m_out.vblank = y >= VA;
      m_out.px     = (x < HA) ? CW'(x) : '0;
      m_out.py     = (y < VA) ? CW'(y) : '0;
      m_out.ls     = x == 0;
      m_out.fs     = m_p == 0;
      if (m_p == 0) m_fc = m_fc + FC_W'(1);
      m_out.fc     = m_fc;
      if (m_pend) begin
        m_p = 0;
        m_pend = 0;
      end else begin
        m_p = (m_p + 1) % F;
      end
    end
    if (r) m_pend = 1;
  endtask

  task automatic check(input string name, input int got, input int want);
    n_tests++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s got=%0d expected=%0d", name, got, want);
    end
  endtask

  // Called at a falling edge: drive inputs, predict the next rising edge, advance.
  task automatic cycle(input bit c, input bit r);
    ce = c;
    resync = r;
    model_step(c, r);
    exp_q.push_back(m_out);
    @(negedge clk_pixel);
  endtask

  task automatic async_reset();
    out_t g;
    ce = 1'b1;
    resync = 1'b0;
    exp_q.push_back(reset_out());
    #2 rst_pixel_n = 1'b0;
    #1 g = dut_out();
    n_tests++;
    if (g !== reset_out()) begin
      n_fail++;
      $display("FAIL async_reset got=%h expected=%h", g, reset_out());
    end
    model_reset();
    @(negedge clk_pixel);
    exp_q.push_back(reset_out());
    @(negedge clk_pixel);
    rst_pixel_n = 1'b1;
  endtask

  // Monitor: every rising edge with a prediction queued gets compared.
  initial begin
    out_t e, g;
    forever begin
      @(posedge clk_pixel);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        g = dut_out();
        n_tests++;
        if (g !== e) begin
          n_fail++;
          $display("FAIL outputs t=%0t got hs=%b vs=%b de=%b bl=%b vb=%b x=%0d y=%0d ls=%b fs=%b fc=%0d expected hs=%b vs=%b de=%b bl=%b vb=%b x=%0d y=%0d ls=%b fs=%b fc=%0d",
                   $time, g.hs, g.vs, g.de, g.blank, g.vblank, g.px, g.py, g.ls, g.fs, g.fc,
                   e.hs, e.vs, e.de, e.blank, e.vblank, e.px, e.py, e.ls, e.fs, e.fc);
        end
      end
    end
  end

  initial begin
    int fs_cyc[$];
    int ls_cyc[$];
    int de_cnt, hs_cnt, vs_cnt;
    out_t g;
    de_cnt = 0; hs_cnt = 0; vs_cnt = 0;
    model_reset();
    #1 rst_pixel_n = 1'b0;
    #2 g = dut_out();
    n_tests++;
    if (g !== reset_out()) begin
      n_fail++;
      $display("FAIL reset_state got=%h expected=%h", g, reset_out());
    end
    @(negedge clk_pixel);
    exp_q.push_back(reset_out());
    @(negedge clk_pixel);
    rst_pixel_n = 1'b1;

    // Continuous enable: measure raster timing directly from the outputs.
    for (int i = 0; i < 3 * F + 4; i++) begin
      cycle(1'b1, 1'b0);
      if (frame_start) fs_cyc.push_back(i);
      if (line_start) ls_cyc.push_back(i);
      if (fs_cyc.size() == 1) begin
        de_cnt += int'(de);
        vs_cnt += int'(vsync == VS_POL);
        if (ls_cyc.size() == 1) hs_cnt += int'(hsync == HS_POL);
      end
    end
    check("first_frame_start_cycle", fs_cyc.size() > 0 ? fs_cyc[0] : -1, 0);
    check("frame_period", fs_cyc.size() > 1 ? fs_cyc[1] - fs_cyc[0] : -1, F);
    check("line_period", ls_cyc.size() > 1 ? ls_cyc[1] - ls_cyc[0] : -1, HT);
    check("de_per_frame", de_cnt, int'(HA * VA));
    check("hsync_active_per_line", hs_cnt, int'(HS));
    check("vsync_active_per_frame", vs_cnt, int'(VS) * HT);

    // Enable on every second clock.
    for (int i = 0; i < 4 * F; i++) cycle(i % 2 == 0, 1'b0);

    // Resync mid-frame, then resync landing on the natural frame wrap.
    for (int i = 0; i < 2 * F; i++) cycle(1'b1, m_p == 5 * HT + 4);
    for (int i = 0; i < 2 * F; i++) cycle(1'b1, m_p == F - 2);

    // Resync held high with irregular enable.
    for (int i = 0; i < 30; i++) cycle(1'($urandom_range(0, 1)), 1'b1);
    for (int i = 0; i < 20; i++) cycle(1'b1, 1'b0);

    // Asynchronous reset mid-line, then randomised enable/resync traffic.
    for (int i = 0; i < HT + 3; i++) cycle(1'b1, 1'b0);
    async_reset();
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) async_reset();
      cycle($urandom_range(0, 3) != 0, $urandom_range(0, 60) == 0);
    end

    @(negedge clk_pixel);
    @(negedge clk_pixel);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
